// File: rtl/time_pkg.sv
// Shared types and constants for the time-of-day counter and the alarm stage.
package time_pkg;

  typedef logic [6:0] time_field_t;

  localparam int SEC_MOD_C = 60;
  localparam int MIN_MOD_C = 60;
  localparam int HRS_MOD_C = 24;
  localparam int DAY_MOD_C = 7;

  // Weekend day codes, also used by the alarm comparator.
  localparam time_field_t DAY_SAT = 7'd6;
  localparam time_field_t DAY_SUN = 7'd0;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-MOD field counter with synchronous clear and a combinational carry-out.
module mod_n_counter
  import time_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output time_field_t value,
  output logic        carry
);

  localparam time_field_t LAST = time_field_t'(MOD - 1);

  time_field_t value_q, value_d;

  // Wrap by comparing against the last legal value, never by bit overflow.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = (value_q == LAST) ? '0 : value_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc && (value_q == LAST);

endmodule

// File: rtl/time_keeper.sv
// Seconds/minutes/hours/day-of-week counter with set mode; optional macro
// TIME_KEEPER_ADV_EDGE_EN makes the advance inputs edge-triggered.
module time_keeper
  import time_pkg::*;
#(
  parameter int SEC_MOD = SEC_MOD_C,
  parameter int MIN_MOD = MIN_MOD_C,
  parameter int HRS_MOD = HRS_MOD_C,
  parameter int DAY_MOD = DAY_MOD_C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_en,
  input  logic        timeset,
  input  logic        minadv,
  input  logic        hrsadv,
  input  logic        dayadv,
  output time_field_t tsec,
  output time_field_t tmin,
  output time_field_t thrs,
  output time_field_t tdays,
  output logic        day_wrap
);

  logic run;
  logic min_step, hrs_step, day_step;
  logic sec_carry, min_carry, hrs_carry, day_carry;
  logic min_inc, hrs_inc, day_inc;
  logic day_wrap_q, day_wrap_d;

  assign run = !timeset;

`ifdef TIME_KEEPER_ADV_EDGE_EN
  logic [2:0] adv_q;
  logic       armed_q;

  // armed_q suppresses a step from a level already high when reset releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adv_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      adv_q   <= {dayadv, hrsadv, minadv};
      armed_q <= 1'b1;
    end
  end

  assign {day_step, hrs_step, min_step} =
    {dayadv, hrsadv, minadv} & ~adv_q & {3{timeset && armed_q}};
`else
  assign {day_step, hrs_step, min_step} =
    {dayadv, hrsadv, minadv} & {3{timeset && tick_en}};
`endif

  // In run mode each field is fed by the carry below it; in set mode only by its own advance.
  assign min_inc = run ? sec_carry : min_step;
  assign hrs_inc = run ? min_carry : hrs_step;
  assign day_inc = run ? hrs_carry : day_step;

  mod_n_counter #(.MOD(SEC_MOD)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run && tick_en),
    .clr   (timeset),
    .value (tsec),
    .carry (sec_carry)
  );

  mod_n_counter #(.MOD(MIN_MOD)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .value (tmin),
    .carry (min_carry)
  );

  mod_n_counter #(.MOD(HRS_MOD)) u_hrs (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hrs_inc),
    .clr   (1'b0),
    .value (thrs),
    .carry (hrs_carry)
  );

  mod_n_counter #(.MOD(DAY_MOD)) u_day (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (day_inc),
    .clr   (1'b0),
    .value (tdays),
    .carry (day_carry)
  );

  assign day_wrap_d = run && hrs_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_wrap_q <= 1'b0;
    end else begin
      day_wrap_q <= day_wrap_d;
    end
  end

  assign day_wrap = day_wrap_q;

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: directed scenarios plus random stimulus
// against a seconds-of-week reference model.
module tb_time_keeper;
  import time_pkg::*;

  localparam int WEEK = 7 * 86400;
`ifdef TIME_KEEPER_ADV_EDGE_EN
  localparam int HOLD_EXP = 7;
`else
  localparam int HOLD_EXP = 11;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_en = 1'b0;
  logic timeset = 1'b0;
  logic minadv = 1'b0;
  logic hrsadv = 1'b0;
  logic dayadv = 1'b0;
  time_field_t tsec, tmin, thrs, tdays;
  logic day_wrap;

  int vectors = 0;
  int miscompares = 0;

  int m_s, m_m, m_h, m_d, m_tot;
  bit m_dw;
  bit sm, sh, sd;
  bit pm, ph, pd, m_armed;

  always #5 clk = ~clk;

  time_keeper dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_en  (tick_en),
    .timeset  (timeset),
    .minadv   (minadv),
    .hrsadv   (hrsadv),
    .dayadv   (dayadv),
    .tsec     (tsec),
    .tmin     (tmin),
    .thrs     (thrs),
    .tdays    (tdays),
    .day_wrap (day_wrap)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_time(input string name, input int h, input int m, input int s, input int d);
    chk({name, "_hrs"}, 32'(thrs), 32'(h));
    chk({name, "_min"}, 32'(tmin), 32'(m));
    chk({name, "_sec"}, 32'(tsec), 32'(s));
    chk({name, "_day"}, 32'(tdays), 32'(d));
  endtask

  // Reference model: run mode is an increment of seconds-of-week.
  initial begin
    m_s = 0; m_m = 0; m_h = 0; m_d = 0; m_dw = 0;
    pm = 0; ph = 0; pd = 0; m_armed = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s = 0; m_m = 0; m_h = 0; m_d = 0; m_dw = 0;
        pm = 0; ph = 0; pd = 0; m_armed = 0;
      end else begin
`ifdef TIME_KEEPER_ADV_EDGE_EN
        sm = timeset && minadv && !pm && m_armed;
        sh = timeset && hrsadv && !ph && m_armed;
        sd = timeset && dayadv && !pd && m_armed;
        pm = minadv; ph = hrsadv; pd = dayadv; m_armed = 1;
`else
        sm = timeset && minadv && tick_en;
        sh = timeset && hrsadv && tick_en;
        sd = timeset && dayadv && tick_en;
`endif
        m_dw = 0;
        if (timeset) begin
          m_s = 0;
          m_m = (m_m + int'(sm)) % 60;
          m_h = (m_h + int'(sh)) % 24;
          m_d = (m_d + int'(sd)) % 7;
        end else if (tick_en) begin
          m_tot = (((m_d * 24 + m_h) * 60 + m_m) * 60 + m_s + 1) % WEEK;
          m_s = m_tot % 60;
          m_m = (m_tot / 60) % 60;
          m_h = (m_tot / 3600) % 24;
          m_d = m_tot / 86400;
          m_dw = (m_tot % 86400) == 0;
        end
      end
    end
  end

  // Compare every cycle outside reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("cycle", {3'b0, tsec, tmin, thrs, tdays, day_wrap},
            {3'b0, 7'(m_s), 7'(m_m), 7'(m_h), 7'(m_d), m_dw});
      end
    end
  end

  task automatic step(input bit t, input bit ts, input bit ma, input bit ha, input bit da);
    tick_en = t; timeset = ts; minadv = ma; hrsadv = ha; dayadv = da;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
  endtask

  // Loads a time starting from the all-zero state; one advance step per pair of cycles.
  task automatic set_time(input int h, input int m, input int d, input int s);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      if (i < h || i < m || i < d) begin
        step(1, 1, i < m, i < h, i < d);
        step(0, 1, 0, 0, 0);
      end
    end
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < s; i++) step(1, 0, 0, 0, 0);
    tick_en = 0; timeset = 0; minadv = 0; hrsadv = 0; dayadv = 0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk_time("reset", 0, 0, 0, 0);
    chk("reset_dw", 32'(day_wrap), 32'd0);

    // Async reset mid-count
    set_time(12, 34, 3, 56);
    chk_time("load", 12, 34, 56, 3);
    #2 rst_n = 1'b0;
    #1 chk_time("async_rst", 0, 0, 0, 0);
    chk("async_rst_dw", 32'(day_wrap), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Full rollover
    do_reset();
    set_time(23, 59, 6, 59);
    chk_time("pre_roll", 23, 59, 59, 6);
    step(1, 0, 0, 0, 0);
    chk_time("roll", 0, 0, 0, 0);
    chk("roll_dw_hi", 32'(day_wrap), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("roll_dw_lo", 32'(day_wrap), 32'd0);

    // Minute carry
    do_reset();
    set_time(0, 0, 0, 58);
    step(1, 0, 0, 0, 0);
    chk_time("carry59", 0, 0, 59, 0);
    step(1, 0, 0, 0, 0);
    chk_time("carry60", 0, 1, 0, 0);

    // Set-mode isolation (set mode wins over a coincident tick)
    do_reset();
    set_time(10, 59, 0, 30);
    step(1, 1, 0, 0, 0);
    chk("iso_clr_sec", 32'(tsec), 32'd0);
    chk("iso_keep_min", 32'(tmin), 32'd59);
    step(1, 1, 1, 0, 0);
    chk_time("iso", 10, 0, 0, 0);
    chk("iso_dw", 32'(day_wrap), 32'd0);

    // Simultaneous advance
    do_reset();
    set_time(5, 10, 6, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    chk_time("simul", 6, 11, 0, 0);

    // Hold hrsadv for five tick periods
    step(0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 1, 0);
      step(0, 1, 0, 1, 0);
    end
    chk("hold_hrs", 32'(thrs), 32'(HOLD_EXP));
    step(0, 1, 0, 0, 0);

    // Advance inputs ignored in run mode
    step(1, 0, 1, 1, 1);
    chk_time("run_ignore", HOLD_EXP, 11, 1, 0);

    // Random stimulus
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 15) == 0) ? !timeset : timeset,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day counter for the lab 2 digital clock. Counts seconds, minutes, hours and day-of-week from a 1 Hz strobe, and supports manual setting through advance inputs. Drives the `tmin`/`thrs`/`tdays` inputs of the alarm comparator and the display path. All counter outputs are registered, so the comparator sees stable values for a full second between updates.

## Interface
Parameters:
- `SEC_MOD`, 60: seconds modulus
- `MIN_MOD`, 60: minutes modulus
- `HRS_MOD`, 24: hours modulus
- `DAY_MOD`, 7: day-of-week modulus. Days are 0..6; 6 and 0 form the weekend.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock
- `rst_n`  in  1: asynchronous active-low reset
- `tick_en`  in  1: one-cycle 1 Hz strobe, synchronous to `clk`
- `timeset`  in  1: set mode; freezes timekeeping and enables the advance inputs
- `minadv`  in  1: advance minutes (set mode only)
- `hrsadv`  in  1: advance hours (set mode only)
- `dayadv`  in  1: advance day (set mode only)
- `tsec`  out  7: seconds, 0..SEC_MOD-1
- `tmin`  out  7: minutes, 0..MIN_MOD-1
- `thrs`  out  7: hours, 0..HRS_MOD-1
- `tdays`  out  7: day of week, 0..DAY_MOD-1
- `day_wrap`  out  1: one-cycle strobe when the hours counter wraps to 0 in run mode

## Operation
- Reset (async assert, any time): `tsec`=`tmin`=`thrs`=`tdays`=0 and `day_wrap`=0. The block releases synchronously on the first `clk` edge after deassertion.
- Run mode (`timeset`=0), on each `tick_en`:
  - `tsec` increments.
  - At SEC_MOD-1 it wraps to 0 and carries into `tmin`.
  - `tmin` carries into `thrs` at MIN_MOD-1.
  - `thrs` carries into `tdays` at HRS_MOD-1 and pulses `day_wrap`.
  - `tdays` wraps from DAY_MOD-1 to 0.
  - Carries ripple within the same edge. 23:59:59 day 6 goes to 00:00:00 day 0 on one tick.
- Set mode (`timeset`=1):
  - Seconds counting stops.
  - `tsec` is cleared to 0 on the first cycle `timeset` is sampled high.
  - Each advance input increments its field modulo its own range, with no carry into the next field.
  - `minadv`, `hrsadv` and `dayadv` are independent. If several are high in the same advance event, each of those fields steps once.
  - `day_wrap` is never asserted in set mode.
- Leaving set mode: counting resumes on the next `tick_en`, starting from `tsec`=0.
- Advance inputs are ignored when `timeset`=0.
- Fields never hold out-of-range values. Each increment is a compare-to-(MOD-1)-then-clear, not a bit-width overflow.

## Timing
- All outputs change only on the rising `clk` edge, except for the async reset.
- Latency: the output update is visible one `clk` after the edge that samples `tick_en`=1 (or the advance event).
- `day_wrap` is high for exactly the one cycle after the edge where `thrs` wrapped.
- `tick_en` held high for N cycles counts N seconds. The block does not filter it.
- If `timeset` rises in the same cycle as `tick_en`, set mode wins: no count occurs and `tsec` clears.

## Configuration
- `TIME_KEEPER_ADV_EDGE_EN`:
  - **Defined:** each advance input is registered. A field steps once per 0→1 transition of its input while `timeset`=1, independent of `tick_en`. Holding the input high yields a single step.
  - **Undefined (lab default):** a field steps on every `tick_en` while its advance input and `timeset` are both high. Holding the input auto-repeats at 1 Hz.
  - Reset clears the edge-detect registers to 0. A level that is already high at reset release does not produce a step.

## Structure
- Package `time_pkg`:
  - typedef `time_field_t` (`logic [6:0]`)
  - constants `SEC_MOD_C`, `MIN_MOD_C`, `HRS_MOD_C`, `DAY_MOD_C`
  - the weekend day codes `DAY_SAT`=6 and `DAY_SUN`=0, shared with the alarm stage
- Sub-module `mod_n_counter`:
  - Parameterised modulus.
  - Inputs: `inc`, `clr`.
  - Outputs: `value` (`time_field_t`) and combinational `carry` (= `inc` && `value`==MOD-1).
  - Instantiated four times.
  - Carry chain and set-mode muxing live in `time_keeper`.

## Test plan
- Reset mid-count:
  - Stimulus: load 12:34:56 day 3, then pulse `rst_n` low between clock edges.
  - Required: all outputs read 0 immediately, with no wait for `clk`.
- Full rollover:
  - Stimulus: set 23:59:59 day 6, then one `tick_en`.
  - Required: next cycle reads 00:00:00 day 0, and `day_wrap`=1 for exactly one cycle.
- Minute carry:
  - Stimulus: from 00:00:58, two ticks.
  - Required: reads 00:00:59, then 00:01:00.
- Set mode isolation:
  - Stimulus: `timeset`=1 at 10:59:30, then `minadv` high for one advance.
  - Required: `tmin`=0 with `thrs` still 10, `tsec`=0, and `day_wrap` stays 0.
- Simultaneous advance:
  - Stimulus: `timeset`=1, with `minadv`, `hrsadv` and `dayadv` all high at 05:10 day 6.
  - Required: after one advance event, reads 06:11 day 0.
- Edge mode (`TIME_KEEPER_ADV_EDGE_EN`):
  - Stimulus: hold `hrsadv` high for 5 `tick_en` periods.
  - Required: `thrs` steps exactly once.
  - Without the macro, the same stimulus steps `thrs` 5 times.
